// File: rtl/flash_boot_streamer.sv
// flash_boot_streamer: reads a ROM image from SPI flash (0x03 read) and
// re-streams every byte, one byte period later, as an SPI mode-0 master
// into the boot loader's slave port.
module flash_boot_streamer #(
  parameter logic [23:0] FLASH_ADDR = 24'h060000,
  parameter int unsigned LENGTH     = 'h4000,
  parameter int unsigned SCK_DIV    = 4
) (
  input  logic clk,
  input  logic reset_b,
  input  logic start,
  output logic flash_SSEL,
  output logic flash_SCK,
  output logic flash_MOSI,
  input  logic flash_MISO,
  output logic bs_SSEL,
  output logic bs_SCK,
  output logic bs_MOSI,
  output logic busy,
  output logic done,
  output logic byte_strobe
);

  localparam int DIV_W = $clog2(SCK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  // A LENGTH of 2^24 truncates to zero and still yields 2^24 bytes,
  // because the last byte is recognised by the count reaching one.
  localparam logic [23:0] LEN24 = 24'(LENGTH);
  localparam logic [31:0] HEADER = {8'h03, FLASH_ADDR};

  typedef enum logic [2:0] {IDLE, CMD, DATA, FLUSH, DONE} state_t;

  state_t           state_q;
  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic             edgeEvt;
  logic             riseNext_q;
  logic [4:0]       bitCnt_q;
  logic [31:0]      cmdSh_q;
  logic [6:0]       rx_q;
  logic [7:0]       hold_q;
  logic             holdValid_q;
  logic [7:0]       tx_q;
  logic             txValid_q;
  logic [23:0]      remain_q;
  logic             lastByte_q;
  logic             flashSsel_q, flashSck_q, bsSsel_q, bsSck_q;
  logic             busy_q, done_q, byteStrobe_q;

  // Half-period divider: the terminal count marks one SCK edge event.
  always_comb begin
    edgeEvt  = (divCnt_q == DIV_LAST);
    divCnt_d = edgeEvt ? '0 : divCnt_q + 1'b1;
  end

  // Sequencer for command, data capture, forwarding and flush.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= IDLE;
      divCnt_q     <= '0;
      riseNext_q   <= 1'b1;
      bitCnt_q     <= '0;
      cmdSh_q      <= '0;
      rx_q         <= '0;
      hold_q       <= '0;
      holdValid_q  <= 1'b0;
      tx_q         <= '0;
      txValid_q    <= 1'b0;
      remain_q     <= '0;
      lastByte_q   <= 1'b0;
      flashSsel_q  <= 1'b1;
      flashSck_q   <= 1'b0;
      bsSsel_q     <= 1'b1;
      bsSck_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      byteStrobe_q <= 1'b0;
    end else begin
      byteStrobe_q <= 1'b0;
      if (state_q != IDLE && state_q != DONE) begin
        divCnt_q <= divCnt_d;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= CMD;
            flashSsel_q <= 1'b0;
            busy_q      <= 1'b1;
            cmdSh_q     <= HEADER;
            divCnt_q    <= '0;
            riseNext_q  <= 1'b1;
            bitCnt_q    <= '0;
            remain_q    <= LEN24;
            lastByte_q  <= 1'b0;
            holdValid_q <= 1'b0;
            txValid_q   <= 1'b0;
            tx_q        <= '0;
          end
        end
        CMD: begin
          if (edgeEvt) begin
            riseNext_q <= !riseNext_q;
            if (riseNext_q) begin
              flashSck_q <= 1'b1;
            end else begin
              flashSck_q <= 1'b0;
              cmdSh_q    <= {cmdSh_q[30:0], 1'b0};
              bitCnt_q   <= bitCnt_q + 5'd1;
              if (bitCnt_q == 5'd31) begin
                state_q  <= DATA;
                bsSsel_q <= 1'b0;
                bitCnt_q <= '0;
              end
            end
          end
        end
        DATA: begin
          if (edgeEvt) begin
            riseNext_q <= !riseNext_q;
            if (riseNext_q) begin
              flashSck_q <= 1'b1;
              if (txValid_q) begin
                bsSck_q <= 1'b1;
              end
              rx_q     <= {rx_q[5:0], flash_MISO};
              bitCnt_q <= bitCnt_q + 5'd1;
              if (bitCnt_q == 5'd7) begin
                hold_q       <= {rx_q, flash_MISO};
                holdValid_q  <= 1'b1;
                byteStrobe_q <= 1'b1;
                remain_q     <= remain_q - 24'd1;
                bitCnt_q     <= '0;
                if (remain_q == 24'd1) begin
                  lastByte_q <= 1'b1;
                end
              end
            end else begin
              flashSck_q <= 1'b0;
              bsSck_q    <= 1'b0;
              if (holdValid_q) begin
                tx_q        <= hold_q;
                txValid_q   <= 1'b1;
                holdValid_q <= 1'b0;
              end else begin
                tx_q <= {tx_q[6:0], 1'b0};
              end
              if (lastByte_q) begin
                state_q     <= FLUSH;
                flashSsel_q <= 1'b1;
                bitCnt_q    <= '0;
              end
            end
          end
        end
        FLUSH: begin
          if (edgeEvt) begin
            riseNext_q <= !riseNext_q;
            if (riseNext_q) begin
              bsSck_q <= 1'b1;
            end else begin
              bsSck_q  <= 1'b0;
              tx_q     <= {tx_q[6:0], 1'b0};
              bitCnt_q <= bitCnt_q + 5'd1;
              if (bitCnt_q == 5'd7) begin
                state_q  <= DONE;
                bsSsel_q <= 1'b1;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
              end
            end
          end
        end
        DONE: begin
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign flash_SSEL  = flashSsel_q;
  assign flash_SCK   = flashSck_q;
  assign flash_MOSI  = cmdSh_q[31];
  assign bs_SSEL     = bsSsel_q;
  assign bs_SCK      = bsSck_q;
  assign bs_MOSI     = tx_q[7];
  assign busy        = busy_q;
  assign done        = done_q;
  assign byte_strobe = byteStrobe_q;

endmodule

// File: tb/tb_flash_boot_streamer.sv
// tb_flash_boot_streamer: two streamer instances (4-byte image at SCK_DIV=4,
// 1-byte image at SCK_DIV=5) driven by a behavioural SPI flash and watched by
// a boot-loader side byte collector.
module tb_flash_boot_streamer;

  localparam int LEN [2] = '{4, 1};
  localparam int DIV [2] = '{4, 5};
  localparam logic [23:0] ADDR [2] = '{24'h012345, 24'hABCDEF};
  // {flashSsel, flashSck, flashMosi, bsSsel, bsSck, bsMosi, busy, done, strobe}
  localparam logic [8:0] RST_OUTS  = 9'b100_100_000;
  localparam logic [8:0] DONE_OUTS = 9'b100_100_010;

  logic clk = 1'b0;
  logic reset_b = 1'b1;
  logic [1:0] start = 2'b00;
  logic [1:0] miso = 2'b00;
  logic [1:0] flashSsel, flashSck, flashMosi, bsSsel, bsSck, bsMosi;
  logic [1:0] busy, done, byteStrobe;

  logic [7:0]  flashMem [2][8];
  logic [31:0] hdr [2];
  logic [7:0]  bsShift [2];
  logic [7:0]  bsBytes [2][8];
  int riseCnt [2], bsRiseCnt [2], strobeCnt [2];
  int sselFallCyc [2], sselRiseCyc [2], bsSselFallCyc [2];
  int firstBsRiseCyc [2], doneCyc [2], lastStrobeCyc [2];
  logic [1:0] prevFSsel = 2'b11, prevFSck = 2'b00;
  logic [1:0] prevBSsel = 2'b11, prevBSck = 2'b00, prevDone = 2'b00;
  logic [8:0] idleBad [2];
  int cycleCnt = 0;
  int assertCnt = 0;
  int failCnt = 0;

  flash_boot_streamer #(.FLASH_ADDR(24'h012345), .LENGTH(4), .SCK_DIV(4)) u_dut0 (
    .clk(clk), .reset_b(reset_b), .start(start[0]),
    .flash_SSEL(flashSsel[0]), .flash_SCK(flashSck[0]), .flash_MOSI(flashMosi[0]),
    .flash_MISO(miso[0]), .bs_SSEL(bsSsel[0]), .bs_SCK(bsSck[0]), .bs_MOSI(bsMosi[0]),
    .busy(busy[0]), .done(done[0]), .byte_strobe(byteStrobe[0])
  );

  flash_boot_streamer #(.FLASH_ADDR(24'hABCDEF), .LENGTH(1), .SCK_DIV(5)) u_dut1 (
    .clk(clk), .reset_b(reset_b), .start(start[1]),
    .flash_SSEL(flashSsel[1]), .flash_SCK(flashSck[1]), .flash_MOSI(flashMosi[1]),
    .flash_MISO(miso[1]), .bs_SSEL(bsSsel[1]), .bs_SCK(bsSck[1]), .bs_MOSI(bsMosi[1]),
    .busy(busy[1]), .done(done[1]), .byte_strobe(byteStrobe[1])
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  // Flash model and boot-loader collector, sampled mid-cycle on each clk fall.
  always @(negedge clk) begin
    cycleCnt <= cycleCnt + 1;
    for (int i = 0; i < 2; i++) begin
      prevFSsel[i] <= flashSsel[i];
      prevFSck[i]  <= flashSck[i];
      prevBSsel[i] <= bsSsel[i];
      prevBSck[i]  <= bsSck[i];
      prevDone[i]  <= done[i];
      if (prevFSsel[i] && !flashSsel[i]) begin
        sselFallCyc[i]    <= cycleCnt;
        riseCnt[i]        <= 0;
        bsRiseCnt[i]      <= 0;
        strobeCnt[i]      <= 0;
        hdr[i]            <= '0;
        firstBsRiseCyc[i] <= 1000000000;
        doneCyc[i]        <= 0;
        miso[i]           <= 1'b0;
      end
      if (!prevFSsel[i] && flashSsel[i]) sselRiseCyc[i] <= cycleCnt;
      if (prevBSsel[i] && !bsSsel[i]) bsSselFallCyc[i] <= cycleCnt;
      if (!prevDone[i] && done[i]) doneCyc[i] <= cycleCnt;
      if (!flashSsel[i] && !prevFSck[i] && flashSck[i]) begin
        riseCnt[i] <= riseCnt[i] + 1;
        if (riseCnt[i] < 32) hdr[i] <= {hdr[i][30:0], flashMosi[i]};
      end
      if (!flashSsel[i] && prevFSck[i] && !flashSck[i] && riseCnt[i] >= 32 && riseCnt[i] < 96)
        miso[i] <= flashMem[i][(riseCnt[i] - 32) / 8][7 - ((riseCnt[i] - 32) % 8)];
      if (!prevBSck[i] && bsSck[i]) begin
        bsRiseCnt[i] <= bsRiseCnt[i] + 1;
        bsShift[i]   <= {bsShift[i][6:0], bsMosi[i]};
        if (bsRiseCnt[i] % 8 == 7 && bsRiseCnt[i] / 8 < 8)
          bsBytes[i][bsRiseCnt[i] / 8] <= {bsShift[i][6:0], bsMosi[i]};
        if (bsRiseCnt[i] == 0) firstBsRiseCyc[i] <= cycleCnt;
      end
      if (byteStrobe[i]) begin
        strobeCnt[i]     <= strobeCnt[i] + 1;
        lastStrobeCyc[i] <= cycleCnt;
      end
    end
  end

  function automatic logic [8:0] outs(input int i);
    return {flashSsel[i], flashSck[i], flashMosi[i], bsSsel[i], bsSck[i], bsMosi[i],
            busy[i], done[i], byteStrobe[i]};
  endfunction

  task automatic checkOutput(input string tag, input longint got, input longint exp,
                             input longint tol = 0);
    assertCnt++;
    if (got < exp - tol || got > exp + tol) begin
      failCnt++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) tol %0d",
               tag, got, got, exp, exp, tol);
    end
  endtask

  task automatic waitCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic fillMem(input bit fixedData);
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 8; b++)
        flashMem[i][b] = fixedData ? 8'h00 : 8'($urandom);
    if (fixedData) begin
      flashMem[0][0] = 8'hA5;
      flashMem[0][1] = 8'h3C;
      flashMem[0][2] = 8'hFF;
      flashMem[0][3] = 8'h00;
      flashMem[1][0] = 8'h5A;
    end
  endtask

  task automatic waitDone();
    for (int c = 0; c < 4000 && done != 2'b11; c++) waitCycle();
    checkOutput("doneReached", done, 2'b11);
  endtask

  task automatic applyStimulus(input bit doRst, input bit fixedData);
    if (doRst) begin
      reset_b = 1'b0;
      waitCycle();
      waitCycle();
    end
    fillMem(fixedData);
    reset_b = 1'b1;
    start = 2'b11;
    waitDone();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("header[%0d]", i), hdr[i], {8'h03, ADDR[i]});
      checkOutput($sformatf("flashRises[%0d]", i), riseCnt[i], 32 + 8 * LEN[i]);
      checkOutput($sformatf("bsPulses[%0d]", i), bsRiseCnt[i], 8 * LEN[i]);
      checkOutput($sformatf("strobes[%0d]", i), strobeCnt[i], LEN[i]);
      for (int b = 0; b < LEN[i]; b++)
        checkOutput($sformatf("bsByte[%0d][%0d]", i, b), bsBytes[i][b], flashMem[i][b]);
      checkOutput($sformatf("doneTime[%0d]", i), doneCyc[i] - sselFallCyc[i],
                  1 + 2 * DIV[i] * (32 + 8 * LEN[i] + 8), 1);
      checkOutput($sformatf("strobeToDone[%0d]", i), doneCyc[i] - lastStrobeCyc[i],
                  16 * DIV[i], DIV[i]);
      checkOutput($sformatf("bsSetup[%0d]", i),
                  (firstBsRiseCyc[i] - bsSselFallCyc[i]) >= DIV[i], 1);
      checkOutput($sformatf("sselBeforeBs[%0d]", i),
                  sselRiseCyc[i] < firstBsRiseCyc[i], LEN[i] == 1);
      checkOutput($sformatf("doneOuts[%0d]", i), outs(i), DONE_OUTS);
    end
  endtask

  // Test sequence.
  initial begin
    reset_b = 1'b1;
    start = 2'b00;
    #3 reset_b = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) checkOutput($sformatf("resetOuts[%0d]", i), outs(i), RST_OUTS);
    waitCycle();
    waitCycle();
    reset_b = 1'b1;

    idleBad[0] = '0;
    idleBad[1] = '0;
    repeat (100) begin
      waitCycle();
      for (int i = 0; i < 2; i++) idleBad[i] = idleBad[i] | (outs(i) ^ RST_OUTS);
    end
    for (int i = 0; i < 2; i++) checkOutput($sformatf("idleOuts[%0d]", i), idleBad[i], 0);

    applyStimulus(1'b0, 1'b1);

    start = 2'b00;
    repeat (20) waitCycle();
    start = 2'b11;
    repeat (20) waitCycle();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("doneSticky[%0d]", i), outs(i), DONE_OUTS);
      checkOutput($sformatf("noExtraBs[%0d]", i), bsRiseCnt[i], 8 * LEN[i]);
    end

    reset_b = 1'b0;
    waitCycle();
    fillMem(1'b0);
    reset_b = 1'b1;
    start = 2'b11;
    waitCycle();
    waitCycle();
    for (int c = 0; c < 2000 && strobeCnt[0] < 1; c++) waitCycle();
    checkOutput("firstStrobe", strobeCnt[0], 1);
    repeat (3 * DIV[0]) waitCycle();
    #1 reset_b = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) checkOutput($sformatf("abortOuts[%0d]", i), outs(i), RST_OUTS);

    applyStimulus(1'b1, 1'b0);
    for (int r = 0; r < 3; r++) applyStimulus(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
